ahmes_acc_flags: RTL and testbench

//  Accumulator (AC) and status-flag register (N Z C V B) stage of the Ahmes datapath.

---
 rtl/ahmes_acc_flags.sv | 165 ++++++++++++++++
 tb/tb_ahmes_acc_flags.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahmes_acc_flags.sv
// Ahmes accumulator and N/Z/C/V/B flag stage: drives the ALU, writes back results, evaluates branches.
// Optional macro EXEC_ERR_EN adds an err output that pulses with done for illegal opcodes.
module ahmes_acc_flags #(
   parameter int DATA_W  = 8,
   parameter bit RESET_Z = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [3:0]        ex_op,
   input  logic              ex_lda,
   input  logic [DATA_W-1:0] ex_operand,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_cin,
   input  logic [DATA_W-1:0] alu_res,
   input  logic              alu_n,
   input  logic              alu_z,
   input  logic              alu_c,
   input  logic              alu_borrow,  // ALU B flag; alu_b is already operand B
   input  logic              alu_v,
   output logic [DATA_W-1:0] ac,
   output logic              flag_n,
   output logic              flag_z,
   output logic              flag_c,
   output logic              flag_v,
   output logic              flag_b,
   output logic              done,
   input  logic [3:0]        br_cond,
   output logic              br_taken
`ifdef EXEC_ERR_EN
   ,
   output logic              err
`endif
);

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_NOT = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_DLE = 4'b0111;
   localparam logic [3:0] OP_DLD = 4'b1000;
   localparam logic [3:0] OP_DAE = 4'b1001;
   localparam logic [3:0] OP_DAD = 4'b1010;

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t state, state_nxt;
   logic   lda_r;
   logic   accept;
   logic   wr_acnz, wr_c, wr_v, wr_b, illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ex_ready  = 1'b0;
      case (state)
         IDLE: begin
            ex_ready = 1'b1;
            if (ex_valid) state_nxt = EXEC;
         end
         EXEC:    state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = ex_valid && ex_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_op <= 4'b0000;
         alu_b  <= '0;
         lda_r  <= 1'b0;
      end else if (accept) begin
         alu_op <= ex_op;
         alu_b  <= ex_operand;
         lda_r  <= ex_lda;
      end
   end

   assign alu_a   = ac;
   assign alu_cin = ((alu_op == OP_DLE) || (alu_op == OP_DLD)) ? flag_c : 1'b0;

   // Which state elements each opcode is allowed to write; the rest hold.
   always_comb begin
      wr_acnz = 1'b0;
      wr_c    = 1'b0;
      wr_v    = 1'b0;
      wr_b    = 1'b0;
      illegal = 1'b0;
      case (alu_op)
         OP_ADD: begin wr_acnz = 1'b1; wr_c = 1'b1; wr_v = 1'b1; end
         OP_SUB: begin wr_acnz = 1'b1; wr_v = 1'b1; wr_b = 1'b1; end
         OP_OR, OP_AND, OP_NOT, OP_XOR: wr_acnz = 1'b1;
         OP_DLE, OP_DLD, OP_DAE, OP_DAD: begin wr_acnz = 1'b1; wr_c = 1'b1; end
         default: illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ac     <= '0;
         flag_n <= 1'b0;
         flag_z <= RESET_Z;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
         flag_b <= 1'b0;
      end else if (state == EXEC) begin
         if (lda_r) begin
            ac     <= alu_b;
            flag_n <= alu_b[DATA_W-1];
            flag_z <= (alu_b == '0);
         end else begin
            if (wr_acnz) begin
               ac     <= alu_res;
               flag_n <= alu_n;
               flag_z <= alu_z;
            end
            if (wr_c) flag_c <= alu_c;
            if (wr_v) flag_v <= alu_v;
            if (wr_b) flag_b <= alu_borrow;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) done <= 1'b0;
      else     done <= (state == EXEC);
   end

`ifdef EXEC_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err <= 1'b0;
      else     err <= (state == EXEC) && !lda_r && illegal;
   end
`endif

   always_comb begin
      br_taken = 1'b0;
      case (br_cond)
         4'b0000: br_taken = 1'b1;
         4'b0001: br_taken = flag_n;
         4'b0010: br_taken = !flag_n;
         4'b0011: br_taken = flag_v;
         4'b0100: br_taken = !flag_v;
         4'b0101: br_taken = flag_z;
         4'b0110: br_taken = !flag_z;
         4'b0111: br_taken = flag_c;
         4'b1000: br_taken = !flag_c;
         4'b1001: br_taken = flag_b;
         4'b1010: br_taken = !flag_b;
         default: br_taken = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ahmes_acc_flags.sv
// Randomized bench for ahmes_acc_flags: an ALU responder, an arithmetic reference model,
// a per-cycle compare process and a few hand-computed directed checks.
module tb_ahmes_acc_flags;

   logic       clk = 1'b0;
   logic       rst;
   logic       ex_valid, ex_ready, ex_lda;
   logic [3:0] ex_op;
   logic [7:0] ex_operand;
   logic [3:0] alu_op;
   logic [7:0] alu_a, alu_b, alu_res, ac;
   logic       alu_cin, alu_n, alu_z, alu_c, alu_borrow, alu_v;
   logic       flag_n, flag_z, flag_c, flag_v, flag_b, done, br_taken;
   logic [3:0] br_cond;
`ifdef EXEC_ERR_EN
   logic       err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ahmes_acc_flags #(.DATA_W(8), .RESET_Z(1'b1)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_lda(ex_lda),
      .ex_operand(ex_operand),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_res(alu_res), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
      .alu_borrow(alu_borrow), .alu_v(alu_v),
      .ac(ac), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
      .flag_b(flag_b), .done(done), .br_cond(br_cond), .br_taken(br_taken)
`ifdef EXEC_ERR_EN
      , .err(err)
`endif
   );

   // Bit-level ALU standing in for the real one.
   logic [8:0] alu_t9;
   always_comb begin
      alu_t9     = 9'd0;
      alu_res    = 8'd0;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      alu_borrow = 1'b0;
      case (alu_op)
         4'd1: begin
            alu_t9  = {1'b0, alu_a} + {1'b0, alu_b};
            alu_res = alu_t9[7:0];
            alu_c   = alu_t9[8];
            alu_v   = (alu_a[7] == alu_b[7]) && (alu_t9[7] != alu_a[7]);
         end
         4'd2: begin
            alu_t9     = {1'b0, alu_a} - {1'b0, alu_b};
            alu_res    = alu_t9[7:0];
            alu_borrow = alu_t9[8];
            alu_v      = (alu_a[7] != alu_b[7]) && (alu_t9[7] != alu_a[7]);
         end
         4'd3:  alu_res = alu_a | alu_b;
         4'd4:  alu_res = alu_a & alu_b;
         4'd5:  alu_res = ~alu_a;
         4'd6:  alu_res = alu_a ^ alu_b;
         4'd7:  begin alu_res = {alu_a[6:0], alu_cin};  alu_c = alu_a[7]; end
         4'd8:  begin alu_res = {alu_cin, alu_a[7:1]};  alu_c = alu_a[0]; end
         4'd9:  begin alu_res = {alu_a[6:0], 1'b0};     alu_c = alu_a[7]; end
         4'd10: begin alu_res = {alu_a[7], alu_a[7:1]}; alu_c = alu_a[0]; end
         default: alu_res = 8'd0;
      endcase
      alu_n = alu_res[7];
      alu_z = (alu_res == 8'd0);
   end

   typedef struct packed {
      logic [7:0] ac;
      logic n, z, c, v, b;
   } st_t;

   localparam st_t RST_ST = '{ac: 8'd0, n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0, b: 1'b0};

   // Integer-arithmetic view of one operation on the architectural state.
   function automatic st_t ref_update(st_t s, logic l, logic [3:0] op, logic [7:0] d);
      st_t o  = s;
      int  a  = int'(s.ac);
      int  b  = int'(d);
      int  sa = a - ((a >= 128) ? 256 : 0);
      int  sb = b - ((b >= 128) ? 256 : 0);
      int  r;
      if (l) begin
         o.ac = d;
         o.n  = (b >= 128);
         o.z  = (b == 0);
         return o;
      end
      case (op)
         4'd1: begin r = a + b; o.c = (r > 255); o.v = ((sa + sb) > 127) || ((sa + sb) < -128); end
         4'd2: begin r = a - b; o.b = (a < b);   o.v = ((sa - sb) > 127) || ((sa - sb) < -128); end
         4'd3:  r = a | b;
         4'd4:  r = a & b;
         4'd5:  r = 255 - a;
         4'd6:  r = a ^ b;
         4'd7:  begin r = a * 2 + (s.c ? 1 : 0);   o.c = (a >= 128); end
         4'd8:  begin r = a / 2 + (s.c ? 128 : 0); o.c = (a % 2 == 1); end
         4'd9:  begin r = a * 2;                    o.c = (a >= 128); end
         4'd10: begin r = a / 2 + ((a >= 128) ? 128 : 0); o.c = (a % 2 == 1); end
         default: return s;
      endcase
      r    = (r + 512) % 256;
      o.ac = 8'(r);
      o.n  = (r >= 128);
      o.z  = (r == 0);
      return o;
   endfunction

   function automatic logic br_ref(logic [3:0] cond, st_t s);
      case (cond)
         4'd0:  return 1'b1;
         4'd1:  return s.n;
         4'd2:  return !s.n;
         4'd3:  return s.v;
         4'd4:  return !s.v;
         4'd5:  return s.z;
         4'd6:  return !s.z;
         4'd7:  return s.c;
         4'd8:  return !s.c;
         4'd9:  return s.b;
         4'd10: return !s.b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: busy countdown (2 = executing, 1 = write-back, 0 = free).
   st_t        m;
   int         cnt;
   logic       m_done, m_err, p_lda;
   logic [3:0] p_op;
   logic [7:0] p_d;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m      <= RST_ST;
         cnt    <= 0;
         m_done <= 1'b0;
         m_err  <= 1'b0;
         p_lda  <= 1'b0;
         p_op   <= 4'd0;
         p_d    <= 8'd0;
      end else begin
         m_done <= (cnt == 2);
         m_err  <= (cnt == 2) && !p_lda && !(p_op inside {[4'd1:4'd10]});
         case (cnt)
            0: if (ex_valid) begin
               p_lda <= ex_lda;
               p_op  <= ex_op;
               p_d   <= ex_operand;
               cnt   <= 2;
            end
            2: begin
               m   <= ref_update(m, p_lda, p_op, p_d);
               cnt <= 1;
            end
            default: cnt <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("ac", int'(ac), int'(m.ac));
         chk("flags_nzcvb", int'({flag_n, flag_z, flag_c, flag_v, flag_b}),
             int'({m.n, m.z, m.c, m.v, m.b}));
         chk("ex_ready", int'(ex_ready), (cnt == 0) ? 1 : 0);
         chk("done", int'(done), int'(m_done));
         chk("br_taken", int'(br_taken), int'(br_ref(br_cond, m)));
`ifdef EXEC_ERR_EN
         chk("err", int'(err), int'(m_err));
`endif
         if (cnt == 2) begin
            chk("alu_a", int'(alu_a), int'(m.ac));
            chk("alu_b", int'(alu_b), int'(p_d));
            chk("alu_op", int'(alu_op), int'(p_op));
            chk("alu_cin", int'(alu_cin), ((p_op == 4'd7) || (p_op == 4'd8)) ? int'(m.c) : 0);
         end
      end
   end

   // Issues one operation from IDLE and returns once the stage is idle again.
   task automatic do_op(input logic l, input logic [3:0] op, input logic [7:0] d,
                        output int lat, output logic cin);
      int t = 0;
      while (!ex_ready && t < 10) begin
         @(posedge clk); #1;
         t++;
      end
      ex_lda = l; ex_op = op; ex_operand = d; ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(negedge clk);
      cin = alu_cin;
      lat = 1;
      while (!done && lat < 6) begin
         @(negedge clk);
         lat++;
      end
      if (!done) chk("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   int   lat;
   logic cin;

   initial begin
      rst = 1'b1; ex_valid = 1'b0; ex_lda = 1'b0; ex_op = 4'd0; ex_operand = 8'd0;
      br_cond = 4'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_ac", int'(ac), 0);
      chk("rst_flags", int'({flag_n, flag_z, flag_c, flag_v, flag_b}), 5'b01000);
      chk("rst_ready", int'(ex_ready), 1);
      br_cond = 4'b0101; #1;
      chk("rst_br_z", int'(br_taken), 1);

      do_op(1'b1, 4'd0, 8'd127, lat, cin);
      do_op(1'b0, 4'd1, 8'd1, lat, cin);
      chk("add_latency", lat, 2);
      chk("add_ac", int'(ac), 128);
      chk("add_flags", int'({flag_n, flag_z, flag_c, flag_v, flag_b}), 5'b10010);

      do_op(1'b1, 4'd0, 8'd0, lat, cin);
      do_op(1'b0, 4'd2, 8'd1, lat, cin);
      chk("sub_ac", int'(ac), 255);
      chk("sub_flags", int'({flag_n, flag_z, flag_c, flag_v, flag_b}), 5'b10001);
      br_cond = 4'b1001; #1;
      chk("sub_br_b", int'(br_taken), 1);

      do_op(1'b1, 4'd0, 8'd255, lat, cin);
      do_op(1'b0, 4'd1, 8'd2, lat, cin);
      chk("carry_set", int'(flag_c), 1);
      do_op(1'b1, 4'd0, 8'd129, lat, cin);
      do_op(1'b0, 4'd7, 8'd0, lat, cin);
      chk("dle_cin", int'(cin), 1);
      chk("dle_ac", int'(ac), 3);
      chk("dle_c", int'(flag_c), 1);
      do_op(1'b1, 4'd0, 8'd129, lat, cin);
      do_op(1'b0, 4'd8, 8'd0, lat, cin);
      chk("dld_ac", int'(ac), 192);

      do_op(1'b1, 4'd0, 8'd10, lat, cin);
      ex_lda = 1'b0; ex_op = 4'd1; ex_operand = 8'd1; ex_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1 ex_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("held_valid_ac", int'(ac), 12);
      do_op(1'b0, 4'b1100, 8'd55, lat, cin);
      chk("nop_latency", lat, 2);
      chk("nop_ac", int'(ac), 12);

      do_op(1'b1, 4'd0, 8'd5, lat, cin);
      ex_lda = 1'b0; ex_op = 4'd1; ex_operand = 8'd3; ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      rst = 1'b1; #1;
      chk("abort_ac", int'(ac), 0);
      chk("abort_flags", int'({flag_n, flag_z, flag_c, flag_v, flag_b}), 5'b01000);
      chk("abort_ready", int'(ex_ready), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_done", int'(done), 0);
      end
      @(posedge clk); #1;
      chk("abort_ac_after", int'(ac), 0);

      for (int i = 0; i < 300; i++) begin
         br_cond = 4'($urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         do_op(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
               8'($urandom_range(0, 255)), lat, cin);
         chk("rand_latency", lat, 2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
